// File: rtl/dlmac_link_pkg.sv
// ============================================================================
// Module      : dlmac_link_pkg
// Description : Shared widths, DLFloat constants, TX state encoding and a
//               small helper for the DLFloat MAC host link engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dlmac_link_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    localparam int EXP_W  = 6;
    localparam int MANT_W = 9;

    localparam logic [WORD_W-1:0] DLF_NAN  = 16'hFFFF;
    localparam logic [WORD_W-1:0] DLF_ZERO = 16'h0000;

    // Transmit sequencer: one operand word per cycle, A before B.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } tx_state_e;

    // All-ones is the single NaN encoding the tile produces.
    function automatic logic dlf_is_nan(input logic [WORD_W-1:0] w);
        return (w == DLF_NAN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dlmac_link_rx.sv
// ============================================================================
// Module      : dlmac_link_rx
// Description : Result reassembly for the DLFloat MAC host. A matured token
//               marks the high-byte cycle; the low byte follows one cycle
//               later and the 16-bit result is presented the cycle after.
//               Also flags tokens that mature in the wrong phase (sticky).
//               Optional macro: DLMAC_HOST_NAN_FLAG_EN builds the NaN flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dlmac_link_rx
    import dlmac_link_pkg::*;
#(
    parameter bit HI_PHASE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hi_strobe,
    input  logic              ph,
    input  logic [BYTE_W-1:0] link_in,
    output logic              res_valid,
    output logic [WORD_W-1:0] res_data,
    output logic              res_nan,
    output logic              phase_err,
    output logic              rx_busy
);

    logic [BYTE_W-1:0] hi_q,        hi_d;
    logic              lo_pend_q,   lo_pend_d;
    logic              res_valid_q, res_valid_d;
    logic [WORD_W-1:0] res_data_q,  res_data_d;
    logic              phase_err_q, phase_err_d;

    // Capture hi on the token cycle, complete the word on the following cycle.
    always_comb begin
        hi_d        = hi_strobe ? link_in : hi_q;
        lo_pend_d   = hi_strobe;
        res_valid_d = lo_pend_q;
        res_data_d  = lo_pend_q ? {hi_q, link_in} : res_data_q;
        phase_err_d = phase_err_q | (hi_strobe & (ph != HI_PHASE));
    end

    // Reassembly state; reset drops any partially captured result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q        <= '0;
            lo_pend_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= DLF_ZERO;
            phase_err_q <= 1'b0;
        end else begin
            hi_q        <= hi_d;
            lo_pend_q   <= lo_pend_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            phase_err_q <= phase_err_d;
        end
    end

`ifdef DLMAC_HOST_NAN_FLAG_EN
    logic res_nan_q, res_nan_d;

    // NaN flag is aligned with the result pulse it describes.
    always_comb begin
        res_nan_d = lo_pend_q & dlf_is_nan({hi_q, link_in});
    end

    // NaN flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_nan_q <= 1'b0;
        end else begin
            res_nan_q <= res_nan_d;
        end
    end

    assign res_nan = res_nan_q;
`else
    assign res_nan = 1'b0;
`endif

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign phase_err = phase_err_q;
    assign rx_busy   = lo_pend_q | res_valid_q;

endmodule

`default_nettype wire

// File: rtl/dlmac_link_host.sv
// ============================================================================
// Module      : dlmac_link_host
// Description : Host-side link engine for the pin-multiplexed DLFloat MAC
//               tile. Serialises operand pairs onto the 16-bit link (A then
//               B), tracks in-flight results with a token shift register and
//               reassembles the returning byte stream.
//               Optional macro: DLMAC_HOST_NAN_FLAG_EN (NaN result flag).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dlmac_link_host
    import dlmac_link_pkg::*;
#(
    parameter int LAT      = 4,
    parameter bit HI_PHASE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    output logic [WORD_W-1:0] link_out,
    input  logic [BYTE_W-1:0] link_in,
    output logic              res_valid,
    output logic [WORD_W-1:0] res_data,
    output logic              res_nan,
    output logic              busy,
    output logic              phase_err
);

    logic              ph_q,     ph_d;
    tx_state_e         state_q,  state_d;
    logic [WORD_W-1:0] a_q,      a_d;
    logic [WORD_W-1:0] b_q,      b_d;
    logic [LAT-1:0]    tokens_q, tokens_d;

    logic              accept;
    logic              send_b;
    logic              rx_busy;

    assign accept = op_valid & op_ready;
    assign send_b = (state_q == SEND_B);

    // Phase bit toggles every cycle; shared reset keeps it aligned to the tile.
    always_comb begin
        ph_d = ~ph_q;
    end

    // Operand holding registers load only on handshake.
    always_comb begin
        a_d = accept ? op_a : a_q;
        b_d = accept ? op_b : b_q;
    end

    // TX state register plus phase, operand and token registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_q     <= 1'b0;
            state_q  <= IDLE;
            a_q      <= DLF_ZERO;
            b_q      <= DLF_ZERO;
            tokens_q <= '0;
        end else begin
            ph_q     <= ph_d;
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tokens_q <= tokens_d;
        end
    end

    // TX next state: accept launches SEND_A, which always lands in ph = 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? SEND_A : IDLE;
            SEND_A:  state_d = SEND_B;
            SEND_B:  state_d = accept ? SEND_A : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // TX outputs: idle link drives zero so the tile accumulates nothing.
    always_comb begin
        link_out = DLF_ZERO;
        op_ready = 1'b0;
        case (state_q)
            IDLE: begin
                link_out = DLF_ZERO;
                op_ready = ph_q;
            end
            SEND_A: begin
                link_out = a_q;
                op_ready = 1'b0;
            end
            SEND_B: begin
                link_out = b_q;
                op_ready = ph_q;
            end
            default: begin
                link_out = DLF_ZERO;
                op_ready = 1'b0;
            end
        endcase
    end

    // Token shift register: a 1 enters on each B-word cycle; MSB marks hi byte.
    generate
        if (LAT == 1) begin : g_tok_single
            always_comb begin
                tokens_d = send_b;
            end
        end else begin : g_tok_shift
            always_comb begin
                tokens_d = {tokens_q[LAT-2:0], send_b};
            end
        end
    endgenerate

    dlmac_link_rx #(
        .HI_PHASE (HI_PHASE)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .hi_strobe (tokens_q[LAT-1]),
        .ph        (ph_q),
        .link_in   (link_in),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_nan   (res_nan),
        .phase_err (phase_err),
        .rx_busy   (rx_busy)
    );

    assign busy = (state_q != IDLE) | (|tokens_q) | rx_busy;

endmodule

`default_nettype wire

// File: doc/dlmac_link_host.md
# dlmac_link_host

Host-side link engine for the pin-multiplexed DLFloat MAC tile. It sits on the other side of the 16-bit operand bus and the 8-bit result bus. It accepts operand pairs over a valid/ready port and time-multiplexes each pair onto the shared 16-bit link as an A-word then a B-word. It then reassembles the returning high/low result bytes into 16-bit results. Its phase counter is aligned to the tile's phase counters by a shared reset.

## Interface
Parameters:
- LAT, 4: cycles from the B-word cycle to the cycle the result high byte is present on link_in; must be ≥1.
- HI_PHASE, 1: value of the phase bit during which link_in carries the result high byte.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- op_valid  in  1  operand pair offered.
- op_ready  out  1  pair accepted when op_valid && op_ready.
- op_a  in  16  DLFloat operand A (1 sign, 6 exp, 9 mantissa).
- op_b  in  16  DLFloat operand B.
- link_out  out  16  operand link to the tile: {uio byte, ui byte}.
- link_in  in  8  result byte stream from the tile.
- res_valid  out  1  one-cycle pulse when res_data is valid.
- res_data  out  16  reassembled result {hi, lo}.
- res_nan  out  1  result equals 16'hFFFF; see Configuration.
- busy  out  1  a pair is registered or any result is in flight.
- phase_err  out  1  sticky; a result token matured in the wrong phase.

## Operation
- ph: a 1-bit free-running phase bit. It is 0 in the first cycle after reset release and toggles every cycle.
- TX FSM states:
  - IDLE: link_out = 0.
  - SEND_A: link_out = A.
  - SEND_B: link_out = B.
- op_ready = (ph == 1) && (state == IDLE || state == SEND_B).
- On accept, op_a and op_b are registered and the next state is SEND_A, which always falls in a ph = 0 cycle. SEND_A always goes to SEND_B.
- SEND_B goes to SEND_A if a new pair is accepted in that cycle, otherwise to IDLE.
- Zero operands in IDLE make the tile's product 0, so idle cycles add nothing.
- Throughput: one pair per 2 cycles, back-to-back with no bubble.
- In-flight tracking uses an LAT-bit token shift register. A 1 is inserted in each SEND_B cycle and the register shifts every cycle. Bit LAT-1 set marks the high-byte cycle.
- RX sequencing:
  - In the high-byte cycle, capture link_in into hi.
  - In the next cycle, capture link_in into lo.
  - In the cycle after that, res_valid = 1 and res_data = {hi, lo}.
  - There is no result back-pressure. The consumer must take every pulse.
- If a token matures with ph != HI_PHASE, phase_err is set and stays set until reset. The result is still delivered.
- busy = (state != IDLE) || (|tokens) || RX capture pending.
- Simultaneous accept and result return are independent and both are serviced in the same cycle.

## Timing
- Reset values:
  - op_ready = 0, link_out = 0, res_valid = 0, res_data = 0, res_nan = 0, busy = 0, phase_err = 0.
  - ph = 0, state = IDLE, tokens cleared.
- The first op_ready = 1 is in the second cycle after reset release (ph = 1).
- Pair accepted at edge cycle t:
  - A on link_out at t+1, B at t+2.
  - High byte sampled at t+2+LAT, low byte at t+3+LAT.
  - res_valid at t+4+LAT.
- With HI_PHASE = 1, LAT must be even, otherwise phase_err fires.
- Reset asserted mid-operation: all tokens and partial bytes are dropped, no res_valid is produced, and link_out returns to 0 on the next edge.
- op_valid deasserted while SEND_A is pending: the already-accepted pair is still sent in full.

## Configuration
- DLMAC_HOST_NAN_FLAG_EN defined: res_nan = 1 in exactly the res_valid cycle when res_data == 16'hFFFF, and 0 otherwise.
- Not defined: res_nan is tied to 0 and no comparator is built.

## Structure
- Shared package dlmac_link_pkg:
  - WORD_W = 16, BYTE_W = 8, EXP_W = 6, MANT_W = 9.
  - DLF_NAN = 16'hFFFF, DLF_ZERO = 16'h0000.
  - TX state enum {IDLE, SEND_A, SEND_B}.
- Sub-module dlmac_link_rx holds the token-driven hi/lo capture, the res_valid/res_nan generation and phase_err. The top level keeps ph, the TX FSM and the token shift register.

## Test plan
All scenarios use a behavioral tile model with LAT = 4 and HI_PHASE = 1 unless stated.
- Reset -> all outputs 0. op_ready is first high 2 cycles after release.
- Single pair op_a = 16'h3E00, op_b = 16'h4000, model returns 16'h4000 -> link_out shows 3E00 then 4000, then 0. res_valid pulses at t+8 with res_data = 16'h4000. busy drops the cycle after.
- Five back-to-back pairs with op_valid held high -> op_ready high every ph = 1 cycle, no idle link cycles, five res_valid pulses spaced 2 cycles apart with matching data.
- Model returns 16'hFFFF -> res_nan = 1 with res_valid when DLMAC_HOST_NAN_FLAG_EN is defined, 0 when it is not.
- LAT = 5 -> the first result sets phase_err, which stays 1 through later results until reset.
- Reset asserted at t+3 of an in-flight pair -> no res_valid afterwards, link_out = 0, busy = 0 the cycle after reset.
